imem_loadable: RTL

Parametrised, writable successor to the processor's fixed instruction ROM. It holds up to NUM_PROG programs in a DEPTH-word instruction store with a registered 1-cycle fetch port for the core, plus a byte-stream loader FSM that writes program images and records each program's start address in a base table. Unwritten words read as FILL, which defaults to 8'hFF and so matches the current ROM default. It sits between the PC/fetch stage and the boot/test harness.

---
 rtl/imem_pkg.sv | 18 +
 rtl/imem_loader_fsm.sv | 74 +++++++
 rtl/imem_loadable.sv | 81 ++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// imem_pkg: shared loader state encoding, stream field order and default opcodes
package imem_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SLOT,
    ST_BASE,
    ST_LEN,
    ST_DATA,
    ST_DONE,
    ST_ERR
  } ld_state_t;
  localparam int FIELD_SLOT = 0;
  localparam int FIELD_BASE = 1;
  localparam int FIELD_LEN = 2;
  localparam int FIELD_DATA = 3;
  localparam logic [7:0] FILL_OP = 8'hFF;
  localparam logic [7:0] HALT_OP = 8'hFF;
endpackage

// File: rtl/imem_loader_fsm.sv
// imem_loader_fsm: stream handshake, field capture, bounds check and write pointer
module imem_loader_fsm import imem_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH = 256,
  parameter int SEL_W = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_start_i,
  input  logic              load_valid_i,
  input  logic [DATA_W-1:0] load_data_i,
  output logic              load_ready_o,
  output logic              load_done_o,
  output logic              load_err_o,
  output logic              busy_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [SEL_W-1:0]  slot_o,
  output logic [ADDR_W-1:0] base_o
);
  localparam int SW = DATA_W + 1;
  ld_state_t state, state_n;
  logic [SEL_W-1:0] slot;
  logic [ADDR_W-1:0] base, ptr;
  logic [DATA_W-1:0] rem;
  logic hs, bad;
  assign load_ready_o = state inside {ST_SLOT, ST_BASE, ST_LEN, ST_DATA};
  assign hs = load_valid_i && load_ready_o;
  assign bad = (SW'(base) + SW'(load_data_i) > SW'(DEPTH)) || (SW'(base) >= SW'(DEPTH));
  assign load_done_o = state == ST_DONE;
  assign load_err_o = state == ST_ERR;
  assign busy_o = state != ST_IDLE;
  assign we_o = hs && state == ST_DATA;
  assign waddr_o = ptr;
  assign wdata_o = load_data_i;
  assign slot_o = slot;
  assign base_o = base;
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: state_n = load_start_i ? ST_SLOT : ST_IDLE;
      ST_SLOT: state_n = hs ? ST_BASE : ST_SLOT;
      ST_BASE: state_n = hs ? ST_LEN : ST_BASE;
      ST_LEN:  state_n = !hs ? ST_LEN : bad ? ST_ERR : (load_data_i == '0) ? ST_DONE : ST_DATA;
      ST_DATA: state_n = (hs && rem == DATA_W'(1)) ? ST_DONE : ST_DATA;
      default: state_n = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= ST_IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot <= '0;
      base <= '0;
      ptr <= '0;
      rem <= '0;
    end else if (hs) begin
      if (state == ST_SLOT) slot <= load_data_i[SEL_W-1:0];
      if (state == ST_BASE) base <= load_data_i[ADDR_W-1:0];
      if (state == ST_LEN) begin
        ptr <= base;
        rem <= load_data_i;
      end
      if (state == ST_DATA) begin
        ptr <= ptr + ADDR_W'(1);
        rem <= rem - DATA_W'(1);
      end
    end
  end
endmodule

// File: rtl/imem_loadable.sv
// imem_loadable: writable instruction store with 1-cycle fetch, written bitmap and program base table
module imem_loadable import imem_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH = 256,
  parameter int NUM_PROG = 4,
  parameter logic [DATA_W-1:0] FILL = DATA_W'(FILL_OP),
  localparam int SEL_W = (NUM_PROG > 1) ? $clog2(NUM_PROG) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              fetch_en_i,
  input  logic [ADDR_W-1:0] address_i,
  output logic [DATA_W-1:0] data_o,
  output logic              data_valid_o,
  input  logic [SEL_W-1:0]  prog_sel_i,
  output logic [ADDR_W-1:0] prog_base_o,
  input  logic              load_start_i,
  input  logic              load_valid_i,
  input  logic [DATA_W-1:0] load_data_i,
  output logic              load_ready_o,
  output logic              load_done_o,
  output logic              load_err_o,
  output logic              busy_o
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0] written;
  logic [ADDR_W-1:0] base_tab [NUM_PROG];
  logic we;
  logic [ADDR_W-1:0] waddr, ld_base;
  logic [DATA_W-1:0] wdata;
  logic [SEL_W-1:0] ld_slot;
  logic fetch, in_range;
  imem_loader_fsm #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH(DEPTH),
    .SEL_W(SEL_W)
  ) u_fsm (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .load_start_i(load_start_i),
    .load_valid_i(load_valid_i),
    .load_data_i(load_data_i),
    .load_ready_o(load_ready_o),
    .load_done_o(load_done_o),
    .load_err_o(load_err_o),
    .busy_o(busy_o),
    .we_o(we),
    .waddr_o(waddr),
    .wdata_o(wdata),
    .slot_o(ld_slot),
    .base_o(ld_base)
  );
  assign fetch = fetch_en_i && !busy_o;
  assign in_range = {1'b0, address_i} < (ADDR_W+1)'(DEPTH);
  assign prog_base_o = base_tab[prog_sel_i];
  always_ff @(posedge clk_i) begin
    if (we) mem[waddr] <= wdata;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) written <= '0;
    else if (we) written[waddr] <= 1'b1;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_PROG; i++) base_tab[i] <= '0;
    end else if (load_done_o) begin
      base_tab[ld_slot] <= ld_base;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_o <= FILL;
      data_valid_o <= 1'b0;
    end else begin
      data_valid_o <= fetch;
      if (fetch) data_o <= (in_range && written[address_i]) ? mem[address_i] : FILL;
    end
  end
endmodule
